// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master and its helpers.
// Imported by spi_master; spi_tick_gen stays generic for reuse by other serial masters.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SCLK_LO  = 3'd2,
        SCLK_HI  = 3'd3,
        CS_HOLD  = 3'd4
    } spi_master_state_e;

    localparam int SPI_BITS    = 8;
    localparam int SPI_MIN_DIV = 4;
    localparam int SPI_BIT_W   = $clog2(SPI_BITS);

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: counts 0..CLK_DIV-1 while clear is low and
// raises tick for the single cycle the count sits at CLK_DIV-1.
module spi_tick_gen #(
    parameter int CLK_DIV = 50,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wrapping on tick keeps the count aligned with every state change of the user.
    always_comb begin
        tick  = !clear && (cnt_q == LAST);
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 single-byte SPI master, MSB first, SCLK = clk / (2*CLK_DIV).
// Optional back-to-back frames with cs held low: define SPI_MASTER_BURST_EN.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 50,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic       ready,
    output logic [7:0] rx_data,
    output logic       done,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs
);

    // Dividers below the slave's synchronizer minimum are raised to it.
    localparam int DIV_EFF = (CLK_DIV < SPI_MIN_DIV) ? SPI_MIN_DIV : CLK_DIV;

    spi_master_state_e state_q, state_d;

    logic                 cs_q, cs_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 done_q, done_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic [7:0]           tx_shift_q, tx_shift_d;
    logic [7:0]           rx_shift_q, rx_shift_d;
    logic [SPI_BIT_W-1:0] bit_cnt_q, bit_cnt_d;

    logic tick;
    logic last_bit;
    logic burst_window;

    spi_tick_gen #(
        .CLK_DIV (DIV_EFF),
        .CNT_W   (CNT_W)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (state_q == IDLE),
        .tick  (tick)
    );

    assign last_bit = (bit_cnt_q == SPI_BIT_W'(SPI_BITS - 1));

`ifdef SPI_MASTER_BURST_EN
    assign burst_window = (state_q == SCLK_HI) && tick && last_bit;
`else
    assign burst_window = 1'b0;
`endif

    assign ready = (state_q == IDLE) || burst_window;

    always_comb begin
        state_d    = state_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        done_d     = 1'b0;
        rx_data_d  = rx_data_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    tx_shift_d = tx_data;
                    mosi_d     = tx_data[7];
                    cs_d       = 1'b0;
                    state_d    = CS_SETUP;
                end
            end

            CS_SETUP: begin
                if (tick) begin
                    state_d = SCLK_LO;
                end
            end

            // miso is only looked at here, so a floating line elsewhere never reaches rx.
            SCLK_LO: begin
                if (tick) begin
                    sclk_d     = 1'b1;
                    rx_shift_d = {rx_shift_q[6:0], miso};
                    state_d    = SCLK_HI;
                end
            end

            SCLK_HI: begin
                if (tick) begin
                    sclk_d = 1'b0;
                    if (!last_bit) begin
                        bit_cnt_d  = bit_cnt_q + SPI_BIT_W'(1);
                        tx_shift_d = {tx_shift_q[6:0], tx_shift_q[7]};
                        mosi_d     = tx_shift_q[6];
                        state_d    = SCLK_LO;
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = CS_HOLD;
`ifdef SPI_MASTER_BURST_EN
                        if (start) begin
                            rx_data_d  = rx_shift_q;
                            done_d     = 1'b1;
                            tx_shift_d = tx_data;
                            mosi_d     = tx_data[7];
                            state_d    = SCLK_LO;
                        end
`endif
                    end
                end
            end

            CS_HOLD: begin
                if (tick) begin
                    cs_d      = 1'b1;
                    mosi_d    = 1'b0;
                    rx_data_d = rx_shift_q;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_data_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            done_q     <= done_d;
            rx_data_q  <= rx_data_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign cs      = cs_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master with a behavioural mode-0 slave and loopback option.
// Expectations follow the frame timing rules (18*DIV+1 latency, 16*DIV burst spacing).
module tb_spi_master;

    localparam int DIV       = 4;
    localparam int BUDGET    = 40 * DIV;
    localparam int FRAME_LAT = 18 * DIV + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] tx_data;
    logic       ready;
    logic [7:0] rx_data;
    logic       done;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       cs;

    int checks = 0;
    int fails  = 0;

    logic       loopback;
    logic [7:0] so_data;
    logic [7:0] so_shift;
    logic [7:0] si_shift;

    spi_master #(
        .CLK_DIV (DIV),
        .CNT_W   (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .tx_data (tx_data),
        .ready   (ready),
        .rx_data (rx_data),
        .done    (done),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso),
        .cs      (cs)
    );

    always #5 clk = ~clk;

    // Behavioural mode-0 slave: loads on cs fall, shifts out on sclk fall, samples on rise.
    always @(negedge cs) so_shift = so_data;
    always @(negedge sclk) if (cs === 1'b0) so_shift = {so_shift[6:0], 1'b0};
    always @(posedge sclk) si_shift = {si_shift[6:0], mosi};

    assign miso = loopback ? mosi : ((cs === 1'b0) ? so_shift[7] : 1'bz);

    task automatic run_frame(input logic [7:0] tx, input int poke_at,
                             output int lat, output int cs_low, output int rises,
                             output logic [7:0] mbits, output logic poke_ready);
        logic prev_sclk;
        start   = 1'b1;
        tx_data = tx;
        @(negedge clk);
        start      = 1'b0;
        tx_data    = 8'($urandom);
        lat        = 0;
        cs_low     = 0;
        rises      = 0;
        mbits      = '0;
        poke_ready = 1'bx;
        prev_sclk  = 1'b0;
        for (int k = 1; k <= BUDGET; k++) begin
            if (cs === 1'b0) cs_low++;
            if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                rises++;
                mbits = {mbits[6:0], mosi};
            end
            prev_sclk = sclk;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (k == poke_at) begin
                start      = 1'b1;
                tx_data    = 8'hFF;
                poke_ready = ready;
            end else if (k == poke_at + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        tx_data  = 8'h00;
        loopback = 1'b1;
        so_data  = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (cs !== 1'b1) begin fails++; $display("[TB] FAIL reset_cs: got %b expected 1", cs); end
        checks++; if (sclk !== 1'b0) begin fails++; $display("[TB] FAIL reset_sclk: got %b expected 0", sclk); end
        checks++; if (mosi !== 1'b0) begin fails++; $display("[TB] FAIL reset_mosi: got %b expected 0", mosi); end
        checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (rx_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_rx: got %h expected 00", rx_data); end
        checks++; if (ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (cs !== 1'b1 || ready !== 1'b1) begin fails++; $display("[TB] FAIL idle_after_reset: got cs=%b ready=%b expected 1 1", cs, ready); end
    endtask

    task automatic test_loopback();
        int         lat, cs_low, rises;
        logic [7:0] mbits, tx;
        logic       pr;
        loopback = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx = (i == 0) ? 8'hA5 : 8'($urandom);
            checks++; if (ready !== 1'b1) begin fails++; $display("[TB] FAIL lb_ready_before: got %b expected 1", ready); end
            run_frame(tx, -10, lat, cs_low, rises, mbits, pr);
            checks++; if (lat != FRAME_LAT) begin fails++; $display("[TB] FAIL lb_latency: got %0d expected %0d", lat, FRAME_LAT); end
            checks++; if (cs_low != 18 * DIV) begin fails++; $display("[TB] FAIL lb_cs_low: got %0d expected %0d", cs_low, 18 * DIV); end
            checks++; if (rises != 8) begin fails++; $display("[TB] FAIL lb_sclk_rises: got %0d expected 8", rises); end
            checks++; if (mbits !== tx) begin fails++; $display("[TB] FAIL lb_mosi_bits: got %h expected %h", mbits, tx); end
            checks++; if (rx_data !== tx) begin fails++; $display("[TB] FAIL lb_rx: got %h expected %h", rx_data, tx); end
            checks++; if (ready !== 1'b1) begin fails++; $display("[TB] FAIL lb_ready_done: got %b expected 1", ready); end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL lb_done_pulse: got %b expected 0", done); end
            checks++; if (rx_data !== tx) begin fails++; $display("[TB] FAIL lb_rx_hold: got %h expected %h", rx_data, tx); end
        end
    endtask

    task automatic test_slave();
        int         lat, cs_low, rises;
        logic [7:0] mbits, tx;
        logic       pr;
        loopback = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx      = (i == 0) ? 8'hC7 : 8'($urandom);
            so_data = (i == 0) ? 8'h3C : 8'($urandom);
            @(negedge clk);
            run_frame(tx, -10, lat, cs_low, rises, mbits, pr);
            checks++; if (lat != FRAME_LAT) begin fails++; $display("[TB] FAIL sl_latency: got %0d expected %0d", lat, FRAME_LAT); end
            checks++; if (rx_data !== so_data) begin fails++; $display("[TB] FAIL sl_master_rx: got %h expected %h", rx_data, so_data); end
            checks++; if (si_shift !== tx) begin fails++; $display("[TB] FAIL sl_slave_rx: got %h expected %h", si_shift, tx); end
            @(negedge clk);
        end
        loopback = 1'b1;
    endtask

    task automatic test_ignore_start();
        int         lat, cs_low, rises, extra;
        logic [7:0] mbits, tx;
        logic       pr;
        loopback = 1'b1;
        tx       = 8'($urandom) & 8'h7E;
        run_frame(tx, 20, lat, cs_low, rises, mbits, pr);
        checks++; if (pr !== 1'b0) begin fails++; $display("[TB] FAIL ign_ready_mid: got %b expected 0", pr); end
        checks++; if (lat != FRAME_LAT) begin fails++; $display("[TB] FAIL ign_latency: got %0d expected %0d", lat, FRAME_LAT); end
        checks++; if (mbits !== tx) begin fails++; $display("[TB] FAIL ign_mosi_bits: got %h expected %h", mbits, tx); end
        checks++; if (rx_data !== tx) begin fails++; $display("[TB] FAIL ign_rx: got %h expected %h", rx_data, tx); end
        extra = 0;
        repeat (2 * FRAME_LAT) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin fails++; $display("[TB] FAIL ign_extra_done: got %0d expected 0", extra); end
    endtask

    task automatic test_reset_mid();
        int         lat, cs_low, rises, extra;
        logic [7:0] mbits, tx;
        logic       pr;
        tx = 8'($urandom) | 8'h01;
        run_frame(tx, -10, lat, cs_low, rises, mbits, pr);
        @(negedge clk);
        start   = 1'b1;
        tx_data = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (cs !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_cs: got %b expected 1", cs); end
        checks++; if (sclk !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_sclk: got %b expected 0", sclk); end
        checks++; if (ready !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_ready: got %b expected 1", ready); end
        checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_done: got %b expected 0", done); end
        checks++; if (rx_data !== 8'h00) begin fails++; $display("[TB] FAIL rstmid_rx: got %h expected 00", rx_data); end
        extra = 0;
        repeat (FRAME_LAT + 10) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin fails++; $display("[TB] FAIL rstmid_no_done: got %0d expected 0", extra); end
    endtask

    task automatic test_back_to_back();
        int         d1, d2, cs_hi, extra;
        int         exp_d1, exp_gap, exp_cs_hi, exp_extra;
        logic [7:0] r1, r2;
        bit         seen1;
`ifdef SPI_MASTER_BURST_EN
        exp_d1    = 17 * DIV + 1;
        exp_gap   = 16 * DIV;
        exp_cs_hi = 0;
        exp_extra = 1;
`else
        exp_d1    = FRAME_LAT;
        exp_gap   = FRAME_LAT;
        exp_cs_hi = 1;
        exp_extra = 0;
`endif
        loopback = 1'b1;
        d1 = 0; d2 = 0; cs_hi = 0; seen1 = 1'b0; r1 = '0; r2 = '0;
        start   = 1'b1;
        tx_data = 8'h01;
        @(negedge clk);
        tx_data = 8'h80;
        for (int k = 1; k <= 3 * BUDGET; k++) begin
            if (done === 1'b1 && seen1) begin
                d2 = k;
                r2 = rx_data;
                break;
            end
            if (done === 1'b1) begin
                d1    = k;
                r1    = rx_data;
                seen1 = 1'b1;
            end
            if (seen1 && cs === 1'b1) cs_hi++;
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (d1 != exp_d1) begin fails++; $display("[TB] FAIL b2b_first_done: got %0d expected %0d", d1, exp_d1); end
        checks++; if (d2 - d1 != exp_gap) begin fails++; $display("[TB] FAIL b2b_spacing: got %0d expected %0d", d2 - d1, exp_gap); end
        checks++; if (cs_hi != exp_cs_hi) begin fails++; $display("[TB] FAIL b2b_cs_high: got %0d expected %0d", cs_hi, exp_cs_hi); end
        checks++; if (r1 !== 8'h01) begin fails++; $display("[TB] FAIL b2b_rx1: got %h expected 01", r1); end
        checks++; if (r2 !== 8'h80) begin fails++; $display("[TB] FAIL b2b_rx2: got %h expected 80", r2); end
        extra = 0;
        repeat (2 * BUDGET) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checks++; if (extra != exp_extra) begin fails++; $display("[TB] FAIL b2b_trailing_done: got %0d expected %0d", extra, exp_extra); end
        checks++; if (cs !== 1'b1 || ready !== 1'b1) begin fails++; $display("[TB] FAIL b2b_idle: got cs=%b ready=%b expected 1 1", cs, ready); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_slave();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Mode-0 (CPOL=0, CPHA=0) single-byte SPI master. It is the upstream driver for the team's SPI slave port.
- Converts an internal tx_data/start handshake into CS/SCLK/MOSI waveforms, shifting in MISO at the same time. Returns rx_data with a one-cycle done pulse.
- Sits between the host-side controller (FSM or CPU bus bridge) and the external SPI pins.
- MSB first, 8 bits per frame, SCLK derived from clk by a programmable divider.

Parameters:
- CLK_DIV, default 50: clk cycles per SCLK half-period. Legal range 4..65535; the slave's 2-flop SCLK synchronizer needs at least 4.
- CNT_W, default 16: width of the half-period counter. Must hold CLK_DIV-1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a frame; accepted only when ready=1
- tx_data  input  8  byte to transmit; sampled in the accept cycle only
- ready  output  1  master idle and able to accept start
- rx_data  output  8  byte received on MISO; valid when done=1, held until the next done
- done  output  1  one-cycle pulse at frame completion
- sclk  output  1  SPI clock, idles low
- mosi  output  1  SPI data out
- miso  input  1  SPI data in
- cs  output  1  chip select, active low

Behaviour:
- One clock (clk); reset is synchronous and active-high. All outputs except ready are registered.
- Reset values: cs=1, sclk=0, mosi=0, done=0, rx_data=0, ready=1 (state IDLE), bit counter=0, half-period counter=0.
- Half-period tick: the counter runs 0..CLK_DIV-1 in every non-IDLE state. The state advances on the cycle where the counter equals CLK_DIV-1, and the counter returns to 0 on every state change.
- States (enum in package): IDLE, CS_SETUP, SCLK_LO, SCLK_HI, CS_HOLD.
- IDLE:
  - ready = 1 (combinational).
  - start=1 loads the TX shift register with tx_data. Next cycle: cs=0, mosi=tx_data[7], state CS_SETUP.
- CS_SETUP: cs=0, sclk=0 for CLK_DIV cycles, which gives the slave time to load its TX byte. Then go to SCLK_LO.
- SCLK_LO: sclk=0 for CLK_DIV cycles. On exit: sclk<=1, rx_shift<={rx_shift[6:0],miso} (sample on the rising edge), go to SCLK_HI.
- SCLK_HI: sclk=1 for CLK_DIV cycles. On exit: sclk<=0.
  - bit_cnt<7: bit_cnt++, TX shift left by one, mosi<=next bit (shift on the falling edge), go to SCLK_LO.
  - bit_cnt==7: bit_cnt<=0, go to CS_HOLD (or burst, see Optional Feature).
- CS_HOLD: cs=0, sclk=0 for CLK_DIV cycles. On exit: cs<=1, mosi<=0, rx_data<=rx_shift, done<=1, state IDLE.
- Latency: from the accept cycle to the done cycle is exactly 18*CLK_DIV+1 clk cycles.
- done deasserts the following cycle. ready is 1 in the done cycle, so back-to-back start in the done cycle is legal and gives cs high for exactly one cycle.
- start while ready=0 is ignored. No queuing; tx_data changes during a frame have no effect.
- Reset mid-frame: the next edge forces IDLE, cs=1, sclk=0, no done pulse, rx_data cleared.
- miso is never used outside SCLK_LO exit; a tri-stated (X/Z) miso while cs=1 must not propagate.

Optional Feature:
- Macro: SPI_MASTER_BURST_EN.
- Defined:
  - In SCLK_HI with bit_cnt==7, if start=1: rx_data<=rx_shift, done<=1, TX reloaded from tx_data, mosi<=tx_data[7], next state SCLK_LO.
  - cs stays low and CS_HOLD/CS_SETUP are skipped.
  - ready is also 1 during that final SCLK_HI exit cycle.
  - Frame-to-frame spacing is 16*CLK_DIV cycles.
  - If start=0 in that cycle, normal CS_HOLD path.
- Undefined: frames always end with CS_HOLD and cs high; ready only in IDLE.

Decomposition:
- Package spi_pkg holds:
  - typedef enum spi_master_state_e {IDLE, CS_SETUP, SCLK_LO, SCLK_HI, CS_HOLD}
  - localparam SPI_BITS=8
  - localparam SPI_MIN_DIV=4
- Sub-module spi_tick_gen: parameterised CLK_DIV counter with clear input and one-cycle tick output. It is reused later by other serial masters.

Test Plan:
- CLK_DIV=4, tx_data=8'hA5, miso looped to mosi -> cs low for 72 cycles, 8 sclk rising edges, rx_data=8'hA5, done one cycle at accept+73.
- Loopback to the team's spi_slave, which loads so_data=8'h3C on so_ready -> master rx_data=8'h3C, slave si_data=8'hC7 with si_done for tx_data=8'hC7.
- start pulsed while ready=0 mid-frame with tx_data=8'hFF -> ignored; current frame's mosi bits unchanged, only one done.
- reset asserted at accept+20 -> next cycle cs=1, sclk=0, ready=1, no done, rx_data=0.
- start held high continuously, tx_data 8'h01 then 8'h80 -> two frames, cs high exactly one cycle between them (macro undefined); with SPI_MASTER_BURST_EN cs never rises between frames and done spacing=16*CLK_DIV.
